// File: rtl/rx_ctrl_sys.sv
// Receive-side command controller: turns UART RX byte frames into register-file writes/reads
// and ALU operations. Optional inter-byte frame timeout is enabled by defining RX_TIMEOUT_EN.
module rx_ctrl_sys #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RX_P_Data,
    input  logic                  Rd_D_Vld,
    input  logic                  ALU_OUT_Valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  CMD_BUSY,
    output logic                  FRAME_ERR
);

    localparam logic [DATA_WIDTH-1:0] CmdWr    = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRd    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOp = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAlu   = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StWrAddr  = 4'd1,
        StWrData  = 4'd2,
        StRdAddr  = 4'd3,
        StRdWait  = 4'd4,
        StOpA     = 4'd5,
        StOpB     = 4'd6,
        StFun     = 4'd7,
        StAluWait = 4'd8
    } state_e;

    state_e                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  alu_en_q, alu_en_d;
    logic                  clk_gate_en_q, clk_gate_en_d;
    logic                  cmd_busy_q, cmd_busy_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            frame_err_q, frame_err_d;
    logic            timed_state;
`endif

    always_comb begin
        state_d       = state_q;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        alu_en_d      = 1'b0;
        clk_gate_en_d = 1'b0;
        address_d     = address_q;
        wr_data_d     = wr_data_q;
        alu_fun_d     = alu_fun_q;

        case (state_q)
            StIdle: begin
                if (RX_D_VLD) begin
                    if (RX_P_Data == CmdWr) begin
                        state_d = StWrAddr;
                    end else if (RX_P_Data == CmdRd) begin
                        state_d = StRdAddr;
                    end else if (RX_P_Data == CmdAluOp) begin
                        state_d = StOpA;
                    end else if (RX_P_Data == CmdAlu) begin
                        state_d = StFun;
                    end
                end
            end
            StWrAddr: begin
                if (RX_D_VLD) begin
                    address_d = RX_P_Data[ADDR_WIDTH-1:0];
                    state_d   = StWrData;
                end
            end
            StWrData: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_Data;
                    wr_en_d   = 1'b1;
                    state_d   = StIdle;
                end
            end
            StRdAddr: begin
                if (RX_D_VLD) begin
                    address_d = RX_P_Data[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (Rd_D_Vld) begin
                    state_d = StIdle;
                end
            end
            StOpA: begin
                if (RX_D_VLD) begin
                    address_d = '0;
                    wr_data_d = RX_P_Data;
                    wr_en_d   = 1'b1;
                    state_d   = StOpB;
                end
            end
            StOpB: begin
                if (RX_D_VLD) begin
                    address_d = ADDR_WIDTH'(1);
                    wr_data_d = RX_P_Data;
                    wr_en_d   = 1'b1;
                    state_d   = StFun;
                end
            end
            StFun: begin
                if (RX_D_VLD) begin
                    alu_fun_d     = RX_P_Data[FUN_WIDTH-1:0];
                    alu_en_d      = 1'b1;
                    clk_gate_en_d = 1'b1;
                    state_d       = StAluWait;
                end
            end
            StAluWait: begin
                // Gate stays open until the cycle after the ALU reports completion.
                clk_gate_en_d = ~ALU_OUT_Valid;
                if (ALU_OUT_Valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef RX_TIMEOUT_EN
        timed_state = (state_q == StWrAddr) || (state_q == StWrData) || (state_q == StRdAddr) ||
                      (state_q == StOpA) || (state_q == StOpB) || (state_q == StFun);
        frame_err_d = 1'b0;
        if (!timed_state || RX_D_VLD) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            // No byte arrived this cycle, so no strobe or field update is pending.
            cnt_d       = '0;
            state_d     = StIdle;
            frame_err_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
`endif

        cmd_busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            alu_en_q      <= 1'b0;
            clk_gate_en_q <= 1'b0;
            cmd_busy_q    <= 1'b0;
            address_q     <= '0;
            wr_data_q     <= '0;
            alu_fun_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            alu_en_q      <= alu_en_d;
            clk_gate_en_q <= clk_gate_en_d;
            cmd_busy_q    <= cmd_busy_d;
            address_q     <= address_d;
            wr_data_q     <= wr_data_d;
            alu_fun_q     <= alu_fun_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign FRAME_ERR = frame_err_q;
`else
    assign FRAME_ERR = 1'b0;
`endif

    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = clk_gate_en_q;
    assign CMD_BUSY    = cmd_busy_q;
    assign Address     = address_q;
    assign WrData      = wr_data_q;
    assign ALU_FUN     = alu_fun_q;

endmodule

// File: tb/tb_rx_ctrl_sys.sv
// Directed self-checking bench for rx_ctrl_sys; timeout steps run only with RX_TIMEOUT_EN.
module tb_rx_ctrl_sys;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RX_P_Data = 8'h00;
    logic       Rd_D_Vld = 1'b0;
    logic       ALU_OUT_Valid = 1'b0;
    logic       WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_BUSY, FRAME_ERR;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [3:0] ALU_FUN;

    int checks = 0;
    int errors = 0;

    // Cumulative pulse counters, sampled at the active edge.
    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, ferr_cnt = 0;

    rx_ctrl_sys dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_D_VLD     (RX_D_VLD),
        .RX_P_Data    (RX_P_Data),
        .Rd_D_Vld     (Rd_D_Vld),
        .ALU_OUT_Valid(ALU_OUT_Valid),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_GATE_EN  (CLK_GATE_EN),
        .CMD_BUSY     (CMD_BUSY),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (WrEn)      wr_cnt   <= wr_cnt + 1;
        if (RdEn)      rd_cnt   <= rd_cnt + 1;
        if (ALU_EN)    alu_cnt  <= alu_cnt + 1;
        if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte is accepted on the edge after this negedge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_D_VLD  = 1'b1;
        RX_P_Data = b;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic pulse_rd_vld();
        Rd_D_Vld = 1'b1;
        @(negedge CLK);
        Rd_D_Vld = 1'b0;
    endtask

    task automatic pulse_alu_vld();
        ALU_OUT_Valid = 1'b1;
        @(negedge CLK);
        ALU_OUT_Valid = 1'b0;
    endtask

    initial begin
        int wr0, rd0, alu0;
        logic [7:0] burst [5];
        bit seen;

        // Reset state
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("reset_strobes", {WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_BUSY, FRAME_ERR}, 6'b0);
        chk("reset_fields", {Address, WrData, ALU_FUN}, 16'h0);

        // 1: RF write AA,05,3C
        wr0 = wr_cnt;
        send_byte(8'hAA);
        chk("wr_busy_after_cmd", CMD_BUSY, 1'b1);
        send_byte(8'h05);
        chk("wr_no_early_wren", WrEn, 1'b0);
        send_byte(8'h3C);
        chk("wr_wren", WrEn, 1'b1);
        chk("wr_addr", Address, 4'h5);
        chk("wr_data", WrData, 8'h3C);
        chk("wr_busy_clear", CMD_BUSY, 1'b0);
        @(negedge CLK);
        chk("wr_wren_one_cycle", WrEn, 1'b0);
        chk("wr_count", wr_cnt - wr0, 1);

        // 2: RF read BB,0A with stray ALU_OUT_Valid ignored in RD_WAIT
        rd0 = rd_cnt;
        send_byte(8'hBB);
        send_byte(8'h0A);
        chk("rd_rden", RdEn, 1'b1);
        chk("rd_addr", Address, 4'hA);
        chk("rd_busy", CMD_BUSY, 1'b1);
        pulse_alu_vld();
        repeat (2) @(negedge CLK);
        chk("rd_wait_busy", CMD_BUSY, 1'b1);
        chk("rd_rden_low", RdEn, 1'b0);
        pulse_rd_vld();
        chk("rd_done_busy", CMD_BUSY, 1'b0);
        chk("rd_count", rd_cnt - rd0, 1);

        // 3: ALU with operands CC,12,34,02
        wr0 = wr_cnt; alu0 = alu_cnt;
        send_byte(8'hCC);
        send_byte(8'h12);
        chk("opa_wren", WrEn, 1'b1);
        chk("opa_addr_data", {Address, WrData}, {4'h0, 8'h12});
        send_byte(8'h34);
        chk("opb_wren", WrEn, 1'b1);
        chk("opb_addr_data", {Address, WrData}, {4'h1, 8'h34});
        send_byte(8'h02);
        chk("aluop_en", ALU_EN, 1'b1);
        chk("aluop_fun", ALU_FUN, 4'h2);
        chk("aluop_gate", CLK_GATE_EN, 1'b1);
        pulse_rd_vld();
        chk("aluop_en_low", ALU_EN, 1'b0);
        chk("aluop_gate_hold", CLK_GATE_EN, 1'b1);
        chk("aluop_busy_hold", CMD_BUSY, 1'b1);
        pulse_alu_vld();
        chk("aluop_gate_off", CLK_GATE_EN, 1'b0);
        chk("aluop_busy_off", CMD_BUSY, 1'b0);
        chk("aluop_wr_count", wr_cnt - wr0, 2);
        chk("aluop_alu_count", alu_cnt - alu0, 1);

        // 4: ALU no operands DD,07; bytes in ALU_WAIT dropped, incl. one coincident with completion
        wr0 = wr_cnt; alu0 = alu_cnt;
        send_byte(8'hDD);
        send_byte(8'h07);
        chk("alu_en", ALU_EN, 1'b1);
        chk("alu_fun", ALU_FUN, 4'h7);
        send_byte(8'hAA);
        chk("alu_wait_gate", CLK_GATE_EN, 1'b1);
        @(negedge CLK);
        RX_D_VLD = 1'b1; RX_P_Data = 8'hBB; ALU_OUT_Valid = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0; ALU_OUT_Valid = 1'b0;
        chk("alu_coincident_idle", CMD_BUSY, 1'b0);
        chk("alu_gate_off", CLK_GATE_EN, 1'b0);
        send_byte(8'h05);
        chk("alu_dropped_byte", CMD_BUSY, 1'b0);
        chk("alu_no_wr", wr_cnt - wr0, 0);
        chk("alu_count", alu_cnt - alu0, 1);

        // 5: junk byte in IDLE, then reset mid-frame
        wr0 = wr_cnt; rd0 = rd_cnt; alu0 = alu_cnt;
        send_byte(8'h55);
        chk("junk_idle", CMD_BUSY, 1'b0);
        send_byte(8'hAA);
        send_byte(8'h03);
        chk("midframe_addr", Address, 4'h3);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_strobes", {WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_BUSY, FRAME_ERR}, 6'b0);
        chk("rst_fields", {Address, WrData, ALU_FUN}, 16'h0);
        send_byte(8'h3C);
        chk("rst_frame_gone", CMD_BUSY, 1'b0);
        chk("junk_rst_no_strobes", (wr_cnt - wr0) + (rd_cnt - rd0) + (alu_cnt - alu0), 0);

        // Back-to-back frames with RX_D_VLD held high
        wr0 = wr_cnt; rd0 = rd_cnt;
        burst[0] = 8'hAA; burst[1] = 8'h07; burst[2] = 8'h11; burst[3] = 8'hBB; burst[4] = 8'h02;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            RX_D_VLD = 1'b1; RX_P_Data = burst[i];
        end
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        chk("b2b_rden", RdEn, 1'b1);
        chk("b2b_addr", Address, 4'h2);
        chk("b2b_wrdata", WrData, 8'h11);
        chk("b2b_wr_count", wr_cnt - wr0, 1);
        pulse_rd_vld();
        chk("b2b_idle", CMD_BUSY, 1'b0);
        chk("b2b_rd_count", rd_cnt - rd0, 1);

`ifdef RX_TIMEOUT_EN
        // 6: timeout after AA,03 then a clean write
        send_byte(8'hAA);
        send_byte(8'h03);
        seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge CLK);
            if (FRAME_ERR) seen = 1'b1;
        end
        chk("timeout_ferr_seen", seen, 1'b1);
        chk("timeout_idle", CMD_BUSY, 1'b0);
        @(negedge CLK);
        chk("timeout_ferr_one_cycle", FRAME_ERR, 1'b0);
        wr0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'hFF);
        chk("timeout_rewrite", {WrEn, Address, WrData}, {1'b1, 4'h3, 8'hFF});
        chk("timeout_wr_count", wr_cnt - wr0 + 1, 1);
        chk("timeout_ferr_count", ferr_cnt, 1);
`else
        // Without the timeout a partial frame waits indefinitely.
        wr0 = wr_cnt;
        seen = 1'b0;
        send_byte(8'hAA);
        send_byte(8'h03);
        repeat (50) @(negedge CLK);
        chk("no_timeout_busy", CMD_BUSY, 1'b1);
        send_byte(8'hFF);
        chk("no_timeout_write", {WrEn, Address, WrData}, {1'b1, 4'h3, 8'hFF});
        chk("no_timeout_ferr", ferr_cnt, 0);
        @(negedge CLK);
        chk("no_timeout_wr_count", wr_cnt - wr0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
